// File: rtl/vga_ram_arb.sv
// vga_ram_arb: glyph RAM arbiter, display reads win, host writes queue in a FIFO and drain in the allowed window
module vga_ram_arb #(
  parameter int AW = 6,
  parameter int DW = 8,
  parameter int DEPTH = 4,
  parameter int VB_ONLY = 1,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_active,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_q,
  input  logic          vblank,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic [LW-1:0] wr_level,
  output logic [7:0]    miss_cnt,
  input  logic          miss_clr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2;
  logic [1:0]    state, state_nx;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [LW-1:0] level, level_nx;
  logic          push, grant, window, vblank_d, vb_miss;
  assign wr_ready = level != LW'(DEPTH);
  assign wr_level = level;
  assign push     = wr_valid && wr_ready;
  assign window   = VB_ONLY != 0 ? vblank : 1'b1;
  assign grant    = state == DRAIN && !disp_active && level != '0;
  assign level_nx = level + LW'(push) - LW'(grant);
  assign vb_miss  = VB_ONLY != 0 && vblank_d && !vblank && level_nx != '0;
  assign ram_addr = grant ? addr_mem[rptr] : disp_addr;
  assign ram_d    = data_mem[rptr];
  assign ram_we   = grant;
  assign disp_q   = ram_q;
  // next state: wait for the window, drain while it stays open and entries remain
  always_comb begin
    state_nx = state == IDLE ? (push ? (window ? DRAIN : WAIT) : IDLE)
             : state == WAIT ? (level == '0 ? IDLE : window ? DRAIN : WAIT)
             : (level_nx == '0 ? IDLE : !window ? WAIT : DRAIN);
  end
  // FIFO storage needs no reset; pointers and level define validity
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr] <= wr_addr;
      data_mem[wptr] <= wr_data;
    end
  end
  // control state, FIFO pointers, blanking edge detect and miss counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      vblank_d <= 1'b0;
      miss_cnt <= '0;
    end else begin
      state    <= state_nx;
      wptr     <= push ? wptr + 1'b1 : wptr;
      rptr     <= grant ? rptr + 1'b1 : rptr;
      level    <= level_nx;
      vblank_d <= vblank;
      miss_cnt <= miss_clr ? '0 : (vb_miss && miss_cnt != 8'hFF) ? miss_cnt + 8'd1 : miss_cnt;
    end
  end
endmodule

// File: tb/tb_vga_ram_arb.sv
// tb_vga_ram_arb: scoreboard bench for the glyph RAM arbiter with a behavioural RAM
module tb_vga_ram_arb;
  logic       clk = 0, rst_n = 0, disp_active = 0, vblank = 0, wr_valid = 0, miss_clr = 0;
  logic [5:0] disp_addr = 0, wr_addr = 0, ram_addr;
  logic [7:0] wr_data = 0, disp_q, ram_d, ram_q, miss_cnt;
  logic       wr_ready, ram_we;
  logic [2:0] wr_level;
  int tests = 0, fails = 0, wcount = 0;
  logic [7:0]  mem [64];
  logic [7:0]  exp_mem [64];
  logic [13:0] wq [$];
  logic [7:0]  rq [$];
  logic        rd_pend = 0;
  bit          host_on = 0;
  logic [5:0]  tbl [4] = '{6'h05, 6'h20, 6'h21, 6'h10};

  vga_ram_arb dut (
    .clk(clk), .rst_n(rst_n), .disp_active(disp_active), .disp_addr(disp_addr), .disp_q(disp_q),
    .vblank(vblank), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_level(wr_level), .miss_cnt(miss_cnt), .miss_clr(miss_clr), .ram_addr(ram_addr),
    .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) begin
    mem[i] = 8'(i * 3);
    exp_mem[i] = 8'(i * 3);
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    logic [13:0] e;
    @(negedge clk);
    if (rd_pend && rq.size() > 0) check("disp_q", disp_q, rq.pop_front());
    rd_pend = disp_active;
    if (disp_active) rq.push_back(exp_mem[disp_addr]);
    if (ram_we) begin
      wcount++;
      if (wq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_d);
      end else begin
        e = wq.pop_front();
        check("ram_write", {disp_active, ram_addr, ram_d}, {1'b0, e});
        exp_mem[e[13:8]] = e[7:0];
      end
    end
  end

  task automatic push(input logic [5:0] a, input logic [7:0] d);
    int n = 0;
    logic r;
    wr_valid = 1;
    wr_addr = a;
    wr_data = d;
    do begin
      @(negedge clk);
      r = wr_ready;
      @(posedge clk);
      n++;
    end while (!r && n < 300);
    if (r) wq.push_back({a, d});
    else begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got no acceptance expected acceptance within 300 cycles");
    end
    #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (wr_level == 0) break;
      n++;
    end
    check("drain_done", wr_level, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vblank = 1;
    repeat (2) @(posedge clk);
    #1 vblank = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int k, n0;
    disp_addr = 6'h2A;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_wr_level", wr_level, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_ram_addr", ram_addr, 'h2A);
    @(posedge clk);
    #1;
    push(6'h05, 8'hA5);
    wr_valid = 0;
    repeat (3) @(negedge clk);
    check("defer_level", wr_level, 1);
    check("defer_no_we", wcount, 0);
    @(posedge clk);
    #1 vblank = 1;
    wait_empty();
    check("defer_wcount", wcount, 1);
    vblank = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) push(6'(8'h10 + i), 8'(8'h40 + i));
    @(negedge clk);
    check("full_ready", wr_ready, 0);
    check("full_level", wr_level, 4);
    fork
      push(6'h14, 8'h44);
      begin
        @(posedge clk);
        #1 vblank = 1;
      end
    join
    wr_valid = 0;
    wait_empty();
    check("full_wcount", wcount, 6);
    vblank = 0;
    @(posedge clk);
    #1;
    disp_active = 1;
    vblank = 1;
    push(6'h05, 8'h11);
    push(6'h20, 8'h22);
    push(6'h21, 8'h33);
    wr_valid = 0;
    for (int i = 0; i < 12; i++) begin
      disp_active = (i % 2 == 0);
      disp_addr = tbl[i % 4];
      @(negedge clk);
      if (disp_active) check("disp_mux", ram_addr, tbl[i % 4]);
      @(posedge clk);
      #1;
    end
    disp_active = 0;
    wait_empty();
    check("prio_wcount", wcount, 9);
    vblank = 0;
    @(posedge clk);
    #1;
    k = 0;
    host_on = 1;
    fork
      begin
        while (host_on) begin
          push(6'(k), 8'(k ^ 8'h5A));
          k++;
        end
        wr_valid = 0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        frame();
        check("miss_first", miss_cnt, 1);
        repeat (299) frame();
        check("miss_sat", miss_cnt, 255);
        miss_clr = 1;
        @(posedge clk);
        #1 miss_clr = 0;
        @(negedge clk);
        check("miss_clr", miss_cnt, 0);
        host_on = 0;
        vblank = 1;
      end
    join
    wait_empty();
    vblank = 0;
    @(posedge clk);
    #1;
    disp_active = 1;
    vblank = 1;
    push(6'h30, 8'h01);
    push(6'h31, 8'h02);
    push(6'h32, 8'h03);
    wr_valid = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1 disp_active = 0;
    #1 check("rst_mid_we", ram_we, 0);
    wq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_mid_level", wr_level, 0);
    check("rst_mid_ready", wr_ready, 1);
    n0 = wcount;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_writes", wcount, n0);
    check("sb_empty", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
